// File: rtl/approx_mon_pkg.sv
// approx_mon_pkg
// Shared definitions for the approximate-multiplier error monitors:
//   - mon_state_t : sweep FSM states (IDLE, RUN, DONE)
//   - calc_n      : number of samples in one exhaustive sweep, 2^(2W)
//   - calc_sum_w  : width of the error-distance accumulator, 4W
//   - calc_cnt_w  : width of the error counter, 2W+1 (must hold N itself)
package approx_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mon_state_t;

  function automatic int calc_n(input int w);
    return 1 << (2 * w);
  endfunction

  function automatic int calc_sum_w(input int w);
    return 4 * w;
  endfunction

  function automatic int calc_cnt_w(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/approx_ed_calc.sv
// approx_ed_calc
// Combinational exact product and error distance for one multiplier sample.
// Ports:
//   i_a, i_b : operands (W bits, unsigned)
//   i_out    : approximate product under test (OUT_W bits, OUT_W <= 2W)
//   o_exact  : i_a * i_b (2W bits)
//   o_ed     : |o_exact - zext(i_out)| (2W bits)
module approx_ed_calc #(
  parameter int W     = 2,
  parameter int OUT_W = 3
) (
  input  logic [W-1:0]     i_a,
  input  logic [W-1:0]     i_b,
  input  logic [OUT_W-1:0] i_out,
  output logic [2*W-1:0]   o_exact,
  output logic [2*W-1:0]   o_ed
);

  logic [2*W-1:0] w_approx;

  always_comb begin
    // Operands widened first so the product is computed at full 2W width.
    o_exact  = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
    w_approx = (2*W)'(i_out);
    o_ed     = (o_exact >= w_approx) ? (o_exact - w_approx)
                                     : (w_approx - o_exact);
  end

endmodule

// File: rtl/approx_mul_err_monitor.sv
// approx_mul_err_monitor
// Consumes one (a, b, approximate product) sample per handshake during an
// exhaustive a-major operand sweep and accumulates error statistics.
// Handshake: a sample is taken in every cycle where in_valid && in_ready;
// in_ready is high only in RUN, in_valid may drop between samples.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start           : pulse; from IDLE or DONE clears statistics and enters RUN
//   in_valid/in_ready, in_a, in_b, in_out : sample stream
//   busy, done      : sweep running / sweep complete with final statistics
//   err_count, max_ed, sum_ed : error count, max and sum of error distance
//   seq_err         : sticky, a sample arrived out of sweep order
//   dbg_state       : current FSM state
// Optional macro APPROX_MON_FIRST_ERR_EN adds first_err_valid/_a/_b/_out,
// capturing the first erroneous sample of the sweep.
module approx_mul_err_monitor
  import approx_mon_pkg::*;
#(
  parameter int W     = 2,
  parameter int OUT_W = 3   // must not exceed 2*W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_a,
  input  logic [W-1:0]               in_b,
  input  logic [OUT_W-1:0]           in_out,
  output logic                       busy,
  output logic                       done,
  output logic [calc_cnt_w(W)-1:0]   err_count,
  output logic [2*W-1:0]             max_ed,
  output logic [calc_sum_w(W)-1:0]   sum_ed,
  output logic                       seq_err,
  output mon_state_t                 dbg_state
`ifdef APPROX_MON_FIRST_ERR_EN
  ,
  output logic                       first_err_valid,
  output logic [W-1:0]               first_err_a,
  output logic [W-1:0]               first_err_b,
  output logic [OUT_W-1:0]           first_err_out
`endif
);

  localparam int N     = calc_n(W);
  localparam int SUM_W = calc_sum_w(W);
  localparam int CNT_W = calc_cnt_w(W);
  localparam logic [2*W-1:0] IDX_LAST = (2*W)'(N - 1);

  mon_state_t         r_state;
  mon_state_t         w_state_nxt;
  logic               w_clear;
  logic               w_hs;
  logic [2*W-1:0]     r_idx;
  logic [CNT_W-1:0]   r_err_count;
  logic [2*W-1:0]     r_max_ed;
  logic [SUM_W-1:0]   r_sum_ed;
  logic               r_seq_err;
  logic [2*W-1:0]     w_exact;
  logic [2*W-1:0]     w_ed;

  approx_ed_calc #(.W(W), .OUT_W(OUT_W)) u_ed_calc (
    .i_a     (in_a),
    .i_b     (in_b),
    .i_out   (in_out),
    .o_exact (w_exact),
    .o_ed    (w_ed)
  );

  assign in_ready  = (r_state == ST_RUN);
  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign w_hs      = in_valid && in_ready;
  assign err_count = r_err_count;
  assign max_ed    = r_max_ed;
  assign sum_ed    = r_sum_ed;
  assign seq_err   = r_seq_err;
  assign dbg_state = r_state;

  // start only acts outside RUN; w_clear wipes statistics on entry to RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_clear     = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_hs && (r_idx == IDX_LAST)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_err_count <= '0;
      r_max_ed    <= '0;
      r_sum_ed    <= '0;
      r_seq_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clear) begin
        r_idx       <= '0;
        r_err_count <= '0;
        r_max_ed    <= '0;
        r_sum_ed    <= '0;
        r_seq_err   <= 1'b0;
      end else if (w_hs) begin
        r_idx <= r_idx + (2*W)'(1);
        if (w_ed != '0) r_err_count <= r_err_count + CNT_W'(1);
        if (w_ed > r_max_ed) r_max_ed <= w_ed;
        r_sum_ed <= r_sum_ed + SUM_W'(w_ed);
        // Out-of-order samples are flagged but still scored.
        if ({in_a, in_b} != r_idx) r_seq_err <= 1'b1;
      end
    end
  end

`ifdef APPROX_MON_FIRST_ERR_EN
  logic               r_first_err_valid;
  logic [W-1:0]       r_first_err_a;
  logic [W-1:0]       r_first_err_b;
  logic [OUT_W-1:0]   r_first_err_out;

  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      r_first_err_valid <= 1'b0;
      r_first_err_a     <= '0;
      r_first_err_b     <= '0;
      r_first_err_out   <= '0;
    end else if (w_hs && (w_ed != '0) && !r_first_err_valid) begin
      r_first_err_valid <= 1'b1;
      r_first_err_a     <= in_a;
      r_first_err_b     <= in_b;
      r_first_err_out   <= in_out;
    end
  end

  assign first_err_valid = r_first_err_valid;
  assign first_err_a     = r_first_err_a;
  assign first_err_b     = r_first_err_b;
  assign first_err_out   = r_first_err_out;
`endif

endmodule
